// File: rtl/fifo_sync_if.sv
// fifo_sync_if: handshake and status bundle for fifo_sync.
//   master : drives wen/wdata/ren, observes data and status (the FIFO's user).
//   slave  : the FIFO side; drives rdata, flags, count and error pulses.
// Signals:
//   wen, wdata      write request and data
//   ren             read request (pop)
//   rdata           read data
//   full, empty     occupancy extremes
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   count           occupancy 0..2**A_SIZE
//   overflow        one-cycle pulse after a rejected write
//   underflow       one-cycle pulse after a rejected read
interface fifo_sync_if #(
  parameter int unsigned D_SIZE = 8,
  parameter int unsigned A_SIZE = 4
);
  logic              wen;
  logic [D_SIZE-1:0] wdata;
  logic              ren;
  logic [D_SIZE-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [A_SIZE:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wen, wdata, ren,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wen, wdata, ren,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a build-time choice of read mode.
//   FWFT = 0 : rdata is a register loaded on an accepted read (1-cycle latency).
//   FWFT = 1 : rdata shows the head word combinationally while not empty.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (control state only; memory is not reset)
//   bus  fifo_sync_if slave modport carrying requests, data and status
module fifo_sync #(
  parameter int unsigned D_SIZE   = 8,
  parameter int unsigned A_SIZE   = 4,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = 2**A_SIZE - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic       clk,
  input logic       rst,
  fifo_sync_if.slave bus
);

  localparam int unsigned DEPTH = 2**A_SIZE;
  localparam logic [A_SIZE:0] DepthCnt = (A_SIZE+1)'(DEPTH);
  localparam logic [A_SIZE:0] AfCnt    = (A_SIZE+1)'(AF_LEVEL);
  localparam logic [A_SIZE:0] AeCnt    = (A_SIZE+1)'(AE_LEVEL);

  logic [D_SIZE-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit; only the low A_SIZE bits address memory.
  logic [A_SIZE:0] wptr_q, rptr_q, count_q;
  logic            overflow_q, underflow_q;
  logic            full, empty;
  logic            wa, ra;

  // Status comes from registered count only, never from same-cycle requests.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  assign wa = bus.wen & ~full;
  assign ra = bus.ren & ~empty;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wa) wptr_q <= wptr_q + 1'b1;
      if (ra) rptr_q <= rptr_q + 1'b1;
      case ({wa, ra})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q  <= bus.wen & full;
      underflow_q <= bus.ren & empty;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wa && !rst) begin
      mem[wptr_q[A_SIZE-1:0]] <= bus.wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata = mem[rptr_q[A_SIZE-1:0]];
  end else begin : g_std
    logic [D_SIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (ra) begin
        rdata_q <= mem[rptr_q[A_SIZE-1:0]];
      end
    end

    assign bus.rdata = rdata_q;
  end

endmodule
